// File: rtl/xeng_tap_sequencer.sv
// X-engine tap-chain front-end: aligns samples to accumulation windows, strobes tap 0,
// and indexes chain results by baseline/window. Optional watchdog under XENG_SEQ_TIMEOUT_EN.
module xeng_tap_sequencer #(
    parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
    parameter int unsigned N_ANTS              = 8,
    parameter int unsigned N_TAPS              = 5,
    parameter int unsigned INPUT_WIDTH         = 16,
    parameter int unsigned WIN_CNT_BITS        = 16,
    parameter int unsigned TIMEOUT             = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sync_in,
    input  logic                                din_valid,
    input  logic [INPUT_WIDTH-1:0]              din,
    output logic [INPUT_WIDTH-1:0]              dout,
    output logic                                tap_rst,
    input  logic                                acc_valid_in,
    output logic                                res_valid,
    output logic [$clog2(N_TAPS*N_ANTS)-1:0]    bl_idx,
    output logic [WIN_CNT_BITS-1:0]             win_idx,
    output logic                                res_last,
    output logic                                err_gap,
    output logic                                err_sync,
    output logic                                err_timeout,
    output logic                                running
);

    localparam int unsigned SAL     = 1 << SERIAL_ACC_LEN_BITS;
    localparam int unsigned WIN_LEN = N_ANTS * SAL;
    localparam int unsigned N_RES   = N_TAPS * N_ANTS;
    localparam int unsigned PH_W    = $clog2(WIN_LEN);
    localparam int unsigned BL_W    = $clog2(N_RES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("xeng_tap_sequencer: TIMEOUT must be at least 2");
    end

    logic [1:0]              state, state_nxt;
    logic [PH_W-1:0]         phase_ctr, phase_nxt;
    logic [BL_W-1:0]         out_ctr, out_ctr_nxt;
    logic                    tap_rst_nxt;
    logic                    err_gap_nxt, err_sync_nxt;
    logic                    res_valid_nxt, res_last_nxt;
    logic [BL_W-1:0]         bl_idx_nxt;
    logic [WIN_CNT_BITS-1:0] win_idx_nxt;
    logic                    run_enter;
    logic                    acc_run;

    assign run_enter = (state == ST_ARM) && din_valid && sync_in;
    assign acc_run   = (state == ST_RUN) && acc_valid_in;

    // Next-state, input phase tracking and tap strobe generation
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_ctr;
        tap_rst_nxt  = 1'b0;
        err_gap_nxt  = err_gap;
        err_sync_nxt = err_sync;
        case (state)
            ST_IDLE: state_nxt = ST_ARM;
            ST_ARM: begin
                if (din_valid && sync_in) begin
                    state_nxt   = ST_RUN;
                    phase_nxt   = PH_W'(1);
                    tap_rst_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // A gap outranks any sync arriving in the same cycle
                if (!din_valid) begin
                    state_nxt   = ST_ARM;
                    phase_nxt   = '0;
                    tap_rst_nxt = 1'b1;
                    err_gap_nxt = 1'b1;
                end else if (sync_in && (phase_ctr != '0)) begin
                    err_sync_nxt = 1'b1;
                    tap_rst_nxt  = 1'b1;
                    phase_nxt    = PH_W'(1);
                end else begin
                    tap_rst_nxt = (phase_ctr == '0);
                    phase_nxt   = (phase_ctr == PH_W'(WIN_LEN - 1)) ? '0 : phase_ctr + PH_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result indexing; the window number advances once the last result has been shown
    always_comb begin
        out_ctr_nxt   = out_ctr;
        bl_idx_nxt    = bl_idx;
        win_idx_nxt   = win_idx;
        res_valid_nxt = acc_run;
        res_last_nxt  = 1'b0;
        if (acc_run) begin
            bl_idx_nxt   = out_ctr;
            res_last_nxt = (out_ctr == BL_W'(N_RES - 1));
            out_ctr_nxt  = (out_ctr == BL_W'(N_RES - 1)) ? '0 : out_ctr + BL_W'(1);
        end
        if (res_valid && res_last) begin
            win_idx_nxt = win_idx + WIN_CNT_BITS'(1);
        end
        if (run_enter) begin
            out_ctr_nxt = '0;
            win_idx_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_ctr <= '0;
            out_ctr   <= '0;
            dout      <= '0;
            tap_rst   <= 1'b0;
            res_valid <= 1'b0;
            bl_idx    <= '0;
            win_idx   <= '0;
            res_last  <= 1'b0;
            err_gap   <= 1'b0;
            err_sync  <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_ctr <= phase_nxt;
            out_ctr   <= out_ctr_nxt;
            dout      <= din;
            tap_rst   <= tap_rst_nxt;
            res_valid <= res_valid_nxt;
            bl_idx    <= bl_idx_nxt;
            win_idx   <= win_idx_nxt;
            res_last  <= res_last_nxt;
            err_gap   <= err_gap_nxt;
            err_sync  <= err_sync_nxt;
            running   <= (state_nxt == ST_RUN);
        end
    end

`ifdef XENG_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_ctr;

    // Cycles in RUN since the last result (or since RUN entry); saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_ctr      <= '0;
            err_timeout <= 1'b0;
        end else if (run_enter || acc_run) begin
            wd_ctr <= '0;
        end else if ((state == ST_RUN) && (wd_ctr != WD_W'(TIMEOUT))) begin
            wd_ctr <= wd_ctr + WD_W'(1);
            if (wd_ctr == WD_W'(TIMEOUT - 1)) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/xeng_tap_sequencer.md
Name: xeng_tap_sequencer

Overview:
Front-end controller for a chain of X-engine baseline taps. Aligns the incoming antenna sample stream to accumulation windows and drives the chain's reset/sync strobe at every window boundary. On the output end, it indexes the serial accumulation results leaving the last tap by baseline and window. It also flags stream gaps, misaligned syncs and, optionally, missing results.

Parameters:
SERIAL_ACC_LEN_BITS, 7, log2 of the per-tap serial accumulation length (SAL = 2^SERIAL_ACC_LEN_BITS)
N_ANTS, 8, dual-pol antennas per X-engine; power of 2
N_TAPS, 5, baseline taps in the chain (N_ANTS/2+1)
INPUT_WIDTH, 16, antenna bus width (dual pol, all parallel samples)
WIN_CNT_BITS, 16, width of the window counter
TIMEOUT, 4096, result-watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sync_in  in  1  frame-start marker, qualified by din_valid
din_valid  in  1  sample strobe; must stay high for the whole stream
din  in  INPUT_WIDTH  antenna samples
dout  out  INPUT_WIDTH  registered samples to tap 0 (a_del/a_ndel/a_end feed)
tap_rst  out  1  accumulation reset/sync to tap 0, aligned to the first dout sample of each window
acc_valid_in  in  1  valid from the last tap in the chain
res_valid  out  1  registered copy of acc_valid_in while RUN
bl_idx  out  clog2(N_TAPS*N_ANTS)  index of the current result
win_idx  out  WIN_CNT_BITS  window number of the current result
res_last  out  1  high with the final result of a window
err_gap  out  1  sticky: din_valid dropped during RUN
err_sync  out  1  sticky: sync_in arrived at a non-zero phase
err_timeout  out  1  sticky watchdog flag (optional feature)
running  out  1  high in RUN

Behaviour:
- Window length is W = N_ANTS*SAL samples. Each window yields R = N_TAPS*N_ANTS results at the chain end.
- FSM states:
  - IDLE: transitions to ARM on the cycle after rst deasserts.
  - ARM: waits for din_valid&sync_in, then goes to RUN. The sample carrying sync_in has phase 0.
  - RUN: phase_ctr counts 0..W-1 on each din_valid and wraps to 0.
- Leaving RUN: din_valid=0 in RUN sets err_gap, goes to ARM, clears phase_ctr and asserts tap_rst for 1 cycle to flush partial accumulations.
- Datapath and strobe latency:
  - dout <= din every cycle; 1-cycle latency.
  - tap_rst <= (accepted sample phase==0). It is therefore high in the same cycle dout carries phase 0, for exactly 1 cycle per window.
- sync_in handling in RUN:
  - At phase 0: no effect.
  - At phase≠0: set err_sync; treat that sample as phase 0 (phase_ctr restarts at 1 next) and pulse tap_rst with it.
- Result indexing, active only in RUN:
  - On each acc_valid_in: res_valid=1, bl_idx=out_ctr, res_last=(out_ctr==R-1), all registered with 1-cycle latency.
  - out_ctr increments; at R-1 it wraps to 0 and win_idx increments (modulo 2^WIN_CNT_BITS) after the last result is presented.
  - acc_valid_in in IDLE/ARM is ignored.
- Entering RUN clears out_ctr and win_idx.
- Reset values: all outputs 0, FSM=IDLE, counters 0, sticky errors cleared. Only rst clears the sticky errors.
- Reset mid-run: takes effect the next clock. tap_rst is not pulsed by reset itself; taps receive their own reset.
- Simultaneous din_valid drop and sync_in: the gap has priority; sync_in is ignored that cycle.

Optional Feature:
Macro XENG_SEQ_TIMEOUT_EN.
- Defined: in RUN, a watchdog counts cycles since the last acc_valid_in, starting from RUN entry. Reaching TIMEOUT sets sticky err_timeout; the FSM is unaffected.
- Undefined: err_timeout is tied 0 and no counter logic exists.

Test Plan:
All scenarios use SERIAL_ACC_LEN_BITS=2, N_ANTS=4, N_TAPS=3 (W=16, R=12).
1. rst, then continuous din_valid with sync_in on sample 5 -> tap_rst high on dout samples 5, 21, 37; running=1 from the cycle after sample 5 is accepted.
2. Feed 24 acc_valid_in pulses in RUN -> bl_idx 0..11 twice; res_last on the 12th and 24th; win_idx 0 then 1, then 2 afterwards.
3. sync_in at phase 7 in RUN -> err_sync=1, tap_rst pulses with that sample, next tap_rst 16 samples later.
4. Drop din_valid for 1 cycle at phase 9 -> err_gap=1, tap_rst 1-cycle pulse, FSM in ARM; resumes only on the next sync_in.
5. Assert rst at phase 10 with acc_valid_in high -> next cycle all outputs 0, errors cleared, FSM in IDLE.
6. With XENG_SEQ_TIMEOUT_EN and TIMEOUT=32: no acc_valid_in for 32 cycles in RUN -> err_timeout=1. Without the macro -> err_timeout stays 0.
